proc_sequencer: RTL and testbench

Parametrised instruction sequencer for the shared-bus datapath. It owns the instruction register and the step counter, and stalls on an external-data valid handshake. It drives register-file, ALU-staging and bus-source controls for LOAD, COPY, register-register ALU and signed/unsigned immediate instructions. It also flags illegal encodings, pulses `done` per retired instruction and keeps a wrapping retired-instruction count.

---
 rtl/proc_sequencer_if.sv | 38 +++
 rtl/proc_sequencer.sv | 143 ++++++++++++++
 tb/tb_proc_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/proc_sequencer_if.sv
// Control/data bundle between the instruction sequencer and the shared-bus datapath.
// The master side is the sequencer; the datapath (or a bench) takes the slave side.
interface proc_sequencer_if #(
    parameter int DATA_W = 10,
    parameter int RA_W   = 2,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] data_in;
    logic              ext_valid;
    logic              ext;
    logic [DATA_W-1:0] imm;
    logic              imm_en;
    logic [RA_W-1:0]   rin;
    logic [RA_W-1:0]   rout;
    logic              enw;
    logic              enr;
    logic              ain;
    logic              gin;
    logic              gout;
    logic [3:0]        alucont;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [DATA_W-1:0] ir;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  data_in, ext_valid,
        output ext, imm, imm_en, rin, rout, enw, enr, ain, gin, gout,
               alucont, busy, done, illegal, ir, retired
    );

    modport slave (
        output data_in, ext_valid,
        input  ext, imm, imm_en, rin, rout, enw, enr, ain, gin, gout,
               alucont, busy, done, illegal, ir, retired
    );
endinterface

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches into IR, decodes LOAD/COPY/ALU/IMM, and steps the
// datapath controls through T1..T3 with a retired-instruction counter.
module proc_sequencer #(
    parameter int         DATA_W  = 10,
    parameter int         RA_W    = 2,
    parameter int         CNT_W   = 16,
    parameter logic [3:0] ALU_ADD = 4'b0010
) (
    input  logic              clk,
    input  logic              reset,
    proc_sequencer_if.master  bus
);
    localparam int IMM_W = DATA_W - RA_W - 2;

    typedef enum logic [1:0] {FETCH, T1, T2, T3} state_t;

    state_t             state, state_nx;
    logic [DATA_W-1:0]  ir_q;
    logic [CNT_W-1:0]   retired_q;

    logic [RA_W-1:0]    rx, ry;
    logic [3:0]         op;
    logic [1:0]         cls;
    logic               is_load, is_copy, is_alu, is_imm;
    logic [DATA_W-1:0]  imm_val;

    logic               ext_c, imm_en_c, enw_c, enr_c, ain_c, gin_c, gout_c;
    logic               busy_c, done_c, illegal_c;
    logic [RA_W-1:0]    rin_c, rout_c;
    logic [3:0]         alucont_c;

    assign rx  = ir_q[DATA_W-1 -: RA_W];
    assign ry  = ir_q[DATA_W-RA_W-1 -: RA_W];
    assign op  = ir_q[5:2];
    assign cls = ir_q[1:0];

    assign is_load = (cls == 2'b00) && (op == 4'd0);
    assign is_copy = (cls == 2'b00) && (op == 4'd1);
    assign is_alu  = (cls == 2'b00) && (op >= 4'd2) && (op <= 4'd11);
    assign is_imm  = cls[0];

    // cls[1] distinguishes the ones-extended form (11) from zero-extended (01)
    assign imm_val = {{(DATA_W-IMM_W){cls[1]}}, ir_q[DATA_W-RA_W-1:2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && bus.ext_valid)
                ir_q <= bus.data_in;
            if (done_c)
                retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        ext_c     = 1'b0;
        imm_en_c  = 1'b0;
        enw_c     = 1'b0;
        enr_c     = 1'b0;
        ain_c     = 1'b0;
        gin_c     = 1'b0;
        gout_c    = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        rin_c     = '0;
        rout_c    = '0;
        alucont_c = 4'd0;
        busy_c    = (state != FETCH);
        case (state)
            FETCH: begin
                ext_c = 1'b1;
                if (bus.ext_valid) state_nx = T1;
            end
            T1: begin
                if (is_load) begin
                    ext_c  = 1'b1;
                    rin_c  = rx;
                    enw_c  = bus.ext_valid;
                    done_c = bus.ext_valid;
                    if (bus.ext_valid) state_nx = FETCH;
                end else if (is_copy) begin
                    enr_c    = 1'b1;
                    rout_c   = ry;
                    enw_c    = 1'b1;
                    rin_c    = rx;
                    done_c   = 1'b1;
                    state_nx = FETCH;
                end else if (is_alu) begin
                    enr_c    = 1'b1;
                    rout_c   = ry;
                    ain_c    = 1'b1;
                    state_nx = T2;
                end else if (is_imm) begin
                    imm_en_c = 1'b1;
                    ain_c    = 1'b1;
                    state_nx = T2;
                end else begin
                    illegal_c = 1'b1;
                    state_nx  = FETCH;
                end
            end
            T2: begin
                enr_c     = 1'b1;
                rout_c    = rx;
                gin_c     = 1'b1;
                alucont_c = is_imm ? ALU_ADD : op;
                state_nx  = T3;
            end
            T3: begin
                gout_c    = 1'b1;
                enw_c     = 1'b1;
                rin_c     = rx;
                alucont_c = is_imm ? ALU_ADD : op;
                done_c    = 1'b1;
                state_nx  = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    // Reset blanks every output combinationally, including the cycle it first rises
    assign bus.ext     = ~reset & ext_c;
    assign bus.imm_en  = ~reset & imm_en_c;
    assign bus.imm     = (reset || !imm_en_c) ? '0 : imm_val;
    assign bus.enw     = ~reset & enw_c;
    assign bus.enr     = ~reset & enr_c;
    assign bus.ain     = ~reset & ain_c;
    assign bus.gin     = ~reset & gin_c;
    assign bus.gout    = ~reset & gout_c;
    assign bus.busy    = ~reset & busy_c;
    assign bus.done    = ~reset & done_c;
    assign bus.illegal = ~reset & illegal_c;
    assign bus.rin     = reset ? '0 : rin_c;
    assign bus.rout    = reset ? '0 : rout_c;
    assign bus.alucont = reset ? 4'd0 : alucont_c;
    assign bus.ir      = reset ? '0 : ir_q;
    assign bus.retired = reset ? '0 : retired_q;
endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: walks each instruction class step by step
// against hand-computed control words.
module tb_proc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    proc_sequencer_if #(.DATA_W(10), .RA_W(2), .CNT_W(16)) bus ();

    proc_sequencer #(.DATA_W(10), .RA_W(2), .CNT_W(16), .ALU_ADD(4'b0010)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // flags order: ext imm_en enw enr ain gin gout busy done illegal
    localparam logic [9:0] F_FETCH = 10'b1000000000;
    localparam logic [9:0] F_COPY  = 10'b0011000110;
    localparam logic [9:0] F_LDW   = 10'b1000000100;
    localparam logic [9:0] F_LDD   = 10'b1010000110;
    localparam logic [9:0] F_AT1   = 10'b0001100100;
    localparam logic [9:0] F_IT1   = 10'b0100100100;
    localparam logic [9:0] F_T2    = 10'b0001010100;
    localparam logic [9:0] F_T3    = 10'b0010001110;
    localparam logic [9:0] F_ILL   = 10'b0000000101;

    function automatic logic [31:0] pk(input logic [3:0] alu, input logic [1:0] ri,
                                       input logic [1:0] ro, input logic [9:0] f);
        return {14'd0, alu, ri, ro, f};
    endfunction

    function automatic logic [31:0] ctl();
        return {14'd0, bus.alucont, bus.rin, bus.rout,
                bus.ext, bus.imm_en, bus.enw, bus.enr, bus.ain, bus.gin, bus.gout,
                bus.busy, bus.done, bus.illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs then change 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic fetch(input logic [9:0] word);
        bus.data_in   = word;
        bus.ext_valid = 1'b1;
        settle();
        chk("fetch_ctl", ctl(), pk(0, 0, 0, F_FETCH));
        tick();
        bus.ext_valid = 1'b0;
        bus.data_in   = '0;
        settle();
    endtask

    initial begin
        reset         = 1'b1;
        bus.ext_valid = 1'b0;
        bus.data_in   = '0;
        #1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rst_ctl", ctl(), 32'd0);
            chk("rst_ir", 32'(bus.ir), 32'd0);
            chk("rst_retired", 32'(bus.retired), 32'd0);
            tick();
        end
        reset = 1'b0;
        settle();
        chk("post_rst_ctl", ctl(), pk(0, 0, 0, F_FETCH));
        chk("post_rst_retired", 32'(bus.retired), 32'd0);

        // COPY R1 <- R2
        fetch(10'h184);
        chk("copy_t1", ctl(), pk(0, 1, 2, F_COPY));
        chk("copy_ir", 32'(bus.ir), 32'h184);
        tick(); settle();
        chk("copy_retired", 32'(bus.retired), 32'd1);
        chk("copy_back_fetch", ctl(), pk(0, 0, 0, F_FETCH));

        // LOAD R2 with operand arriving after 3 stall cycles
        fetch(10'h200);
        for (int i = 0; i < 3; i++) begin
            chk("load_wait", ctl(), pk(0, 2, 0, F_LDW));
            tick(); settle();
        end
        bus.data_in   = 10'h055;
        bus.ext_valid = 1'b1;
        settle();
        chk("load_take", ctl(), pk(0, 2, 0, F_LDD));
        tick();
        bus.ext_valid = 1'b0;
        settle();
        chk("load_retired", 32'(bus.retired), 32'd2);
        chk("load_ir_kept", 32'(bus.ir), 32'h200);

        // ALU op 0101, Rx=2 Ry=0
        fetch(10'h214);
        chk("alu_t1", ctl(), pk(0, 0, 0, F_AT1));
        tick(); settle();
        chk("alu_t2", ctl(), pk(4'h5, 0, 2, F_T2));
        tick(); settle();
        chk("alu_t3", ctl(), pk(4'h5, 2, 0, F_T3));
        tick(); settle();
        chk("alu_retired", 32'(bus.retired), 32'd3);

        // zero-extended immediate into R3
        fetch(10'h315);
        chk("immz_t1", ctl(), pk(0, 0, 0, F_IT1));
        chk("immz_val", 32'(bus.imm), 32'h005);
        tick(); settle();
        chk("immz_t2", ctl(), pk(4'h2, 0, 3, F_T2));
        chk("immz_t2_imm0", 32'(bus.imm), 32'h0);
        tick(); settle();
        chk("immz_t3", ctl(), pk(4'h2, 3, 0, F_T3));
        tick(); settle();

        // ones-extended immediate
        fetch(10'h3FB);
        chk("immo_t1", ctl(), pk(0, 0, 0, F_IT1));
        chk("immo_val", 32'(bus.imm), 32'h3FE);
        tick(); settle();
        chk("immo_t2", ctl(), pk(4'h2, 0, 3, F_T2));
        tick(); settle();
        chk("immo_t3", ctl(), pk(4'h2, 3, 0, F_T3));
        tick(); settle();
        chk("imm_retired", 32'(bus.retired), 32'd5);

        // illegal: cls=10, then cls=00 op=1100
        fetch(10'h002);
        chk("ill_cls10", ctl(), pk(0, 0, 0, F_ILL));
        tick(); settle();
        chk("ill_back_fetch", ctl(), pk(0, 0, 0, F_FETCH));
        chk("ill_retired", 32'(bus.retired), 32'd5);
        fetch(10'h030);
        chk("ill_op1100", ctl(), pk(0, 0, 0, F_ILL));
        tick(); settle();
        chk("ill2_retired", 32'(bus.retired), 32'd5);

        // op=1011 is the last ALU encoding
        fetch(10'h02C);
        chk("alu11_t1", ctl(), pk(0, 0, 0, F_AT1));
        tick(); settle();
        chk("alu11_t2", ctl(), pk(4'hB, 0, 0, F_T2));
        tick(); settle();
        chk("alu11_t3", ctl(), pk(4'hB, 0, 0, F_T3));
        tick(); settle();
        chk("alu11_retired", 32'(bus.retired), 32'd6);

        // reset asserted during T2 of an ALU instruction
        fetch(10'h214);
        tick(); settle();
        chk("rst_mid_t2", ctl(), pk(4'h5, 0, 2, F_T2));
        reset = 1'b1;
        settle();
        chk("rst_mid_blank", ctl(), 32'd0);
        tick();
        reset = 1'b0;
        settle();
        chk("rst_mid_fetch", ctl(), pk(0, 0, 0, F_FETCH));
        chk("rst_mid_retired", 32'(bus.retired), 32'd0);
        chk("rst_mid_ir", 32'(bus.ir), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("rst_mid_no_enw", 32'(bus.enw), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
